hack_alu_pipe: RTL and testbench

- Parametrised, registered successor to the combinational Hack ALU.
- Keeps the six Hack control bits (zx, nx, zy, ny, f, no) and adds a valid/ready handshake on input and output.
- Adds carry and signed-overflow flags and an optional multi-cycle shift-add multiply mode.
- Sits between the CPU decode stage and the writeback/D-register path.

---
 rtl/hack_alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_hack_alu_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_pipe.sv
// Registered Hack ALU with valid/ready handshakes, carry/overflow flags and an
// optional shift-add multiply that replaces the f operation when mul is set.
module hack_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_out;
  logic               r_zr;
  logic               r_ng;
  logic               r_cy;
  logic               r_ov;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_no;

  logic [WIDTH-1:0]   w_x1;
  logic [WIDTH-1:0]   w_x2;
  logic [WIDTH-1:0]   w_y1;
  logic [WIDTH-1:0]   w_y2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_fout;
  logic [WIDTH-1:0]   w_res;
  logic               w_cy;
  logic               w_ov;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_mres;
  logic               w_mul;
  logic               w_accept;
  logic               w_last;

  // Operand pre-processing and the single-cycle Hack function.
  always_comb begin
    w_x1   = zx ? {WIDTH{1'b0}} : x;
    w_x2   = nx ? ~w_x1 : w_x1;
    w_y1   = zy ? {WIDTH{1'b0}} : y;
    w_y2   = ny ? ~w_y1 : w_y1;
    w_sum  = {1'b0, w_x2} + {1'b0, w_y2};
    w_fout = f ? w_sum[WIDTH-1:0] : (w_x2 & w_y2);
    w_res  = no ? ~w_fout : w_fout;
    // Flags come from the raw adder, before the output inversion.
    w_cy   = f & w_sum[WIDTH];
    w_ov   = f & (w_x2[WIDTH-1] == w_y2[WIDTH-1]) & (w_sum[WIDTH-1] != w_x2[WIDTH-1]);
  end

  // One shift-add step and the final multiply result.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
    w_mres     = r_no ? ~w_acc_next : w_acc_next;
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Handshake: in_ready depends only on state and out_ready.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    w_mul    = mul & MUL_EN;
    w_accept = in_valid & in_ready;
  end

  // Control FSM together with the result, flag and multiplier registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_out    <= {WIDTH{1'b0}};
      r_zr     <= 1'b1;
      r_ng     <= 1'b0;
      r_cy     <= 1'b0;
      r_ov     <= 1'b0;
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_no     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept && w_mul) begin
            r_mcand  <= w_x2;
            r_mplier <= w_y2;
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_no     <= no;
            r_state  <= S_MUL;
          end else if (w_accept) begin
            r_out   <= w_res;
            r_zr    <= (w_res == {WIDTH{1'b0}});
            r_ng    <= w_res[WIDTH-1];
            r_cy    <= w_cy;
            r_ov    <= w_ov;
            r_state <= S_HOLD;
          end else if (r_state == S_HOLD && out_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out   <= w_mres;
            r_zr    <= (w_mres == {WIDTH{1'b0}});
            r_ng    <= w_mres[WIDTH-1];
            r_cy    <= 1'b0;
            r_ov    <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_state <= S_MUL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;
  assign cy        = r_cy;
  assign ov        = r_ov;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed bench for hack_alu_pipe: a 16-bit multiply-capable instance and an
// 8-bit instance with multiply disabled.
module tb_hack_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, out;
  logic        zx, nx, zy, ny, f, no, mul;
  logic        zr, ng, cy, ov;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  x8, y8, out8;
  logic        f8, mul8, zero8;
  logic        zr8, ng8, cy8, ov8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hack_alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );

  hack_alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .zx(zero8), .nx(zero8), .zy(zero8), .ny(zero8), .f(f8), .no(zero8),
    .mul(mul8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
    .zr(zr8), .ng(ng8), .cy(cy8), .ov(ov8)
  );

  // Present one bundle for exactly one edge; called at a falling edge.
  task automatic drive_op(input logic [15:0] xi, input logic [15:0] yi, input logic [6:0] ctl);
    x = xi; y = yi;
    {zx, nx, zy, ny, f, no, mul} = ctl;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out, zr, ng, cy, ov} !== {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b out=%h zr=%b ng=%b cy=%b ov=%b, want v=0 r=1 out=0000 zr=1 ng=0 cy=0 ov=0",
               out_valid, in_ready, out, zr, ng, cy, ov);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_flags();
    logic [15:0] tx[6];
    logic [15:0] ty[6];
    logic [6:0]  tc[6];
    logic [19:0] te[6];
    tx = '{16'h0005, 16'h0003, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h00F0};
    ty = '{16'h0003, 16'h0005, 16'h5678, 16'h0001, 16'h0001, 16'h0FF0};
    tc = '{7'b0000100, 7'b0100110, 7'b1010100, 7'b0000100, 7'b0000100, 7'b0000010};
    te = '{{16'h0008, 4'b0000}, {16'hFFFE, 4'b0110}, {16'h0000, 4'b1000},
           {16'h0000, 4'b1010}, {16'h8000, 4'b0101}, {16'hFF0F, 4'b0100}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_op(tx[i], ty[i], tc[i]);
      n_checks++;
      if ({out_valid, out, zr, ng, cy, ov} !== {1'b1, te[i]}) begin
        n_fail++;
        $display("FAIL add_flags[%0d]: got v=%b out=%h zr/ng/cy/ov=%b%b%b%b, want v=1 out=%h flags=%b",
                 i, out_valid, out, zr, ng, cy, ov, te[i][19:4], te[i][3:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul(input logic [15:0] xi, input logic [15:0] yi,
                          input logic [15:0] exp_out, input logic exp_zr);
    out_ready = 1'b1;
    drive_op(xi, yi, 7'b0000001);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: got in_ready=%b out_valid=%b, want 0 0", i, in_ready, out_valid);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({out_valid, out, zr, cy, ov} !== {1'b1, exp_out, exp_zr, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_result: got v=%b out=%h zr=%b cy=%b ov=%b, want v=1 out=%h zr=%b cy=0 ov=0",
               out_valid, out, zr, cy, ov, exp_out, exp_zr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bx[4];
    logic [15:0] by[4];
    logic [15:0] be[4];
    bx = '{16'h000A, 16'hFFFF, 16'h4000, 16'h0064};
    by = '{16'h0014, 16'h0002, 16'h4000, 16'hFF9D};
    be = '{16'h001E, 16'h0001, 16'h8000, 16'h0001};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(16'h0001, 16'h0002, 7'b0000100);
    for (int i = 0; i < 3; i++) begin
      x = 16'hFFFF; y = 16'hFFFF; in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out, zr, ng, cy, ov} !== {1'b1, 1'b0, 16'h0003, 4'b0000}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got v=%b r=%b out=%h flags=%b%b%b%b, want v=1 r=0 out=0003 flags=0000",
                 i, out_valid, in_ready, out, zr, ng, cy, ov);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(bx[i], by[i], 7'b0000100);
      n_checks++;
      if (out_valid !== 1'b1 || out !== be[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%b out=%h, want v=1 out=%h", i, out_valid, out, be[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    drive_op(16'h0003, 16'h0003, 7'b0000001);
    repeat (4) @(negedge clk);
    n_checks++;
    if (out !== 16'h0001) begin
      n_fail++;
      $display("FAIL mul_keeps_out: got out=%h, want 0001", out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out, zr} !== {1'b0, 1'b1, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got v=%b r=%b out=%h zr=%b, want v=0 r=1 out=0000 zr=1",
               out_valid, in_ready, out, zr);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL aborted_mul[%0d]: got out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_width8();
    x8 = 8'h7F; y8 = 8'h01; f8 = 1'b1; mul8 = 1'b1; out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    n_checks++;
    if ({out_valid8, out8, zr8, ng8, cy8, ov8} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL width8_add: got v=%b out=%h zr/ng/cy/ov=%b%b%b%b, want v=1 out=80 flags=0101",
               out_valid8, out8, zr8, ng8, cy8, ov8);
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; x = 16'h0000; y = 16'h0000;
    {zx, nx, zy, ny, f, no, mul} = 7'b0000000;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = 8'h00; y8 = 8'h00;
    f8 = 1'b0; mul8 = 1'b0; zero8 = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_mul(16'h0007, 16'h0006, 16'h002A, 1'b0);
    test_mul(16'h0100, 16'h0100, 16'h0000, 1'b1);
    test_back_to_back();
    test_reset_mid_mul();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
